// File: rtl/lap_stopwatch_pkg.sv
// Shared types and defaults for the lap stopwatch.
// Stopwatch FSM states and parameter defaults.
package lap_stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sw_state_e;

  localparam int DEF_CNT_W     = 32;
  localparam int DEF_PRESCALE  = 1;
  localparam int DEF_LAP_DEPTH = 4;
  localparam int DEF_WRAP      = 1;
  localparam int PRE_W         = 16;

endpackage

// File: rtl/lap_fifo.sv
// Lap capture FIFO: circular buffer, sync flush,
// head shown straight from storage (zero when empty).
module lap_fifo
  import lap_stopwatch_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // a pop frees the slot, so push into a full FIFO works then
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/lap_stopwatch.sv
// Prescaled up/down stopwatch with wrap/saturate
// terminal handling and a lap capture FIFO.
module lap_stopwatch
  import lap_stopwatch_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int PRESCALE  = DEF_PRESCALE,
  parameter int LAP_DEPTH = DEF_LAP_DEPTH,
  parameter int WRAP      = DEF_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             dir,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             lap,
  input  logic             lap_ready,
  output logic [CNT_W-1:0] count,
  output logic             running,
  output logic             done,
  output logic             ovf,
  output logic             lap_valid,
  output logic [CNT_W-1:0] lap_data,
  output logic             lap_drop
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  sw_state_e        state;
  sw_state_e        state_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [PRE_W-1:0] pre;
  logic [PRE_W-1:0] pre_nxt;
  logic             ovf_nxt;
  logic             drop_nxt;
  logic             tick;

  logic             f_full;
  logic             f_empty;
  logic             f_push;
  logic             f_pop;

  assign lap_valid = !f_empty;
  assign f_pop     = lap_valid && lap_ready;
  assign f_push    = lap && !clear;

  assign running = (state == ST_RUN);
  assign done    = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      count    <= '0;
      pre      <= '0;
      ovf      <= 1'b0;
      lap_drop <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      pre      <= pre_nxt;
      ovf      <= ovf_nxt;
      lap_drop <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    pre_nxt   = pre;
    ovf_nxt   = ovf;
    tick      = 1'b0;

    if (clear) begin
      state_nxt = ST_IDLE;
      count_nxt = '0;
      pre_nxt   = '0;
      ovf_nxt   = 1'b0;
    end else if (load) begin
      state_nxt = ST_IDLE;
      count_nxt = load_val;
      pre_nxt   = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start && !stop) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          // stop freezes the prescaler so phase survives a restart
          if (stop) begin
            state_nxt = ST_IDLE;
          end else if (pre == PRE_LAST) begin
            pre_nxt = '0;
            tick    = 1'b1;
          end else begin
            pre_nxt = pre + PRE_W'(1);
          end
        end
        ST_DONE: ;
        default: state_nxt = ST_IDLE;
      endcase
    end

    if (tick) begin
      if (!dir) begin
        if (count == CNT_MAX) begin
          if (WRAP != 0) begin
            count_nxt = '0;
            ovf_nxt   = 1'b1;
          end else begin
            state_nxt = ST_DONE;
          end
        end else begin
          count_nxt = count + CNT_W'(1);
        end
      end else begin
        if (count == '0) begin
          if (WRAP != 0) begin
            count_nxt = CNT_MAX;
            ovf_nxt   = 1'b1;
          end else begin
            state_nxt = ST_DONE;
          end
        end else begin
          count_nxt = count - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    drop_nxt = lap_drop;
    if (clear)
      drop_nxt = 1'b0;
    else if (f_push && f_full && !f_pop)
      drop_nxt = 1'b1;
  end

  lap_fifo #(
    .WIDTH (CNT_W),
    .DEPTH (LAP_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clear),
    .push  (f_push),
    .pop   (f_pop),
    .din   (count),
    .full  (f_full),
    .empty (f_empty),
    .head  (lap_data)
  );

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: three parameterisations share
// stimulus; a queue-based model is checked every cycle.
module tb_lap_stopwatch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;
  logic       lap = 1'b0;
  logic       lap_ready = 1'b0;

  logic [3:0] cnt_a, cnt_b, ld_a, ld_b;
  logic [7:0] cnt_c, ld_c;
  logic [2:0] run_o, done_o, ovf_o, lv_o, drop_o;

  always #5 clk = ~clk;

  lap_stopwatch #(.CNT_W(4), .PRESCALE(1), .LAP_DEPTH(4), .WRAP(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .dir(dir), .load(load), .load_val(load_val[3:0]), .lap(lap),
    .lap_ready(lap_ready), .count(cnt_a), .running(run_o[0]),
    .done(done_o[0]), .ovf(ovf_o[0]), .lap_valid(lv_o[0]),
    .lap_data(ld_a), .lap_drop(drop_o[0]));

  lap_stopwatch #(.CNT_W(4), .PRESCALE(1), .LAP_DEPTH(4), .WRAP(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .dir(dir), .load(load), .load_val(load_val[3:0]), .lap(lap),
    .lap_ready(lap_ready), .count(cnt_b), .running(run_o[1]),
    .done(done_o[1]), .ovf(ovf_o[1]), .lap_valid(lv_o[1]),
    .lap_data(ld_b), .lap_drop(drop_o[1]));

  lap_stopwatch #(.CNT_W(8), .PRESCALE(4), .LAP_DEPTH(4), .WRAP(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .dir(dir), .load(load), .load_val(load_val), .lap(lap),
    .lap_ready(lap_ready), .count(cnt_c), .running(run_o[2]),
    .done(done_o[2]), .ovf(ovf_o[2]), .lap_valid(lv_o[2]),
    .lap_data(ld_c), .lap_drop(drop_o[2]));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  localparam int NI = 3;
  localparam int M_IDLE = 0;
  localparam int M_RUN = 1;
  localparam int M_DONE = 2;
  localparam int DEPTH = 4;
  int mw[NI] = '{4, 4, 8};
  int mp[NI] = '{1, 1, 4};
  int mwr[NI] = '{1, 0, 1};

  int     m_st[NI];
  longint m_cnt[NI];
  int     m_pre[NI];
  bit     m_ovf[NI];
  bit     m_drp[NI];
  longint m_q[NI][$];

  function automatic void m_reset();
    for (int k = 0; k < NI; k++) begin
      m_st[k] = M_IDLE;
      m_cnt[k] = 0;
      m_pre[k] = 0;
      m_ovf[k] = 1'b0;
      m_drp[k] = 1'b0;
      m_q[k].delete();
    end
  endfunction

  function automatic void m_step(int k);
    longint mask;
    longint old;
    longint nxt;
    bit     pop;
    bit     was_full;
    bit     tk;
    mask = (longint'(1) << mw[k]) - 1;
    old = m_cnt[k];
    pop = (m_q[k].size() > 0) && lap_ready;
    was_full = (m_q[k].size() == DEPTH);
    tk = 1'b0;
    if (clear) begin
      m_q[k].delete();
      m_drp[k] = 1'b0;
    end else begin
      if (pop) void'(m_q[k].pop_front());
      if (lap) begin
        if (was_full && !pop) m_drp[k] = 1'b1;
        else m_q[k].push_back(old);
      end
    end
    if (clear) begin
      m_cnt[k] = 0; m_pre[k] = 0; m_ovf[k] = 1'b0; m_st[k] = M_IDLE;
    end else if (load) begin
      m_cnt[k] = longint'(load_val) & mask; m_pre[k] = 0; m_st[k] = M_IDLE;
    end else if (m_st[k] == M_RUN && stop) begin
      m_st[k] = M_IDLE;
    end else if (m_st[k] == M_IDLE && start && !stop) begin
      m_st[k] = M_RUN;
    end else if (m_st[k] == M_RUN) begin
      m_pre[k] = m_pre[k] + 1;
      if (m_pre[k] == mp[k]) begin
        m_pre[k] = 0;
        tk = 1'b1;
      end
    end
    if (tk) begin
      nxt = dir ? old - 1 : old + 1;
      if (nxt < 0 || nxt > mask) begin
        if (mwr[k] != 0) begin
          m_cnt[k] = nxt & mask;
          m_ovf[k] = 1'b1;
        end else begin
          m_st[k] = M_DONE;
        end
      end else begin
        m_cnt[k] = nxt;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else for (int k = 0; k < NI; k++) m_step(k);
  end

  function automatic logic [7:0] a_cnt(int k);
    case (k)
      0: return {4'd0, cnt_a};
      1: return {4'd0, cnt_b};
      default: return cnt_c;
    endcase
  endfunction

  function automatic logic [7:0] a_ld(int k);
    case (k)
      0: return {4'd0, ld_a};
      1: return {4'd0, ld_b};
      default: return ld_c;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("count[%0d]", k), a_cnt(k), m_cnt[k]);
      chk($sformatf("running[%0d]", k), run_o[k], m_st[k] == M_RUN);
      chk($sformatf("done[%0d]", k), done_o[k], m_st[k] == M_DONE);
      chk($sformatf("ovf[%0d]", k), ovf_o[k], m_ovf[k]);
      chk($sformatf("lap_valid[%0d]", k), lv_o[k], m_q[k].size() > 0);
      chk($sformatf("lap_data[%0d]", k), a_ld(k),
          m_q[k].size() > 0 ? m_q[k][0] : 0);
      chk($sformatf("lap_drop[%0d]", k), drop_o[k], m_drp[k]);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    m_reset();
    #2 rst_n = 1'b0;
    step(2);
    chk("rst_cnt_c", cnt_c, 0);
    chk("rst_run", run_o, 0);
    chk("rst_lv", lv_o, 0);
    rst_n = 1'b1;
    step(2);

    // prescale 4: 40 run cycles give 10 ticks
    start = 1; step(); start = 0;
    step(40);
    stop = 1; step(); stop = 0;
    chk("p4_cnt", cnt_c, 10);
    chk("p4_run", run_o[2], 0);
    step(2);
    start = 1; step(); start = 0;
    step(3);
    chk("p4_before_tick", cnt_c, 10);
    step();
    chk("p4_tick", cnt_c, 11);
    step(2);
    stop = 1; step(); stop = 0;
    start = 1; step(); start = 0;
    step();
    chk("phase_hold", cnt_c, 11);
    step();
    chk("phase_tick", cnt_c, 12);
    stop = 1; step(); stop = 0;

    // terminal value going up
    clear = 1; step(); clear = 0;
    load = 1; load_val = 8'd14; step(); load = 0;
    start = 1; step(); start = 0;
    step();
    chk("up_15", cnt_a, 15);
    step();
    chk("wrap_cnt", cnt_a, 0);
    chk("wrap_ovf", ovf_o[0], 1);
    chk("sat_cnt", cnt_b, 15);
    chk("sat_done", done_o[1], 1);
    chk("sat_ovf", ovf_o[1], 0);
    start = 1; step(); start = 0;
    step();
    chk("done_start", done_o[1], 1);
    chk("done_hold", cnt_b, 15);

    // terminal value going down
    clear = 1; step(); clear = 0;
    dir = 1;
    load = 1; load_val = 8'd3; step(); load = 0;
    start = 1; step(); start = 0;
    step(); chk("dn_2", cnt_a, 2);
    step(); chk("dn_1", cnt_a, 1);
    step(); chk("dn_0", cnt_b, 0);
    step();
    chk("dn_wrap", cnt_a, 15);
    chk("dn_ovf", ovf_o[0], 1);
    chk("dn_sat", cnt_b, 0);
    chk("dn_done", done_o[1], 1);
    stop = 1; step(); stop = 0;
    dir = 0;

    // five laps into a four-entry FIFO
    clear = 1; step(); clear = 0;
    load = 1; load_val = 8'd2; step();
    for (int v = 4; v <= 10; v += 2) begin
      lap = 1; load_val = 8'(v); step();
    end
    load = 0; step(); lap = 0;
    chk("lap_valid", lv_o[0], 1);
    chk("lap_drop", drop_o[0], 1);
    lap_ready = 1;
    for (int e = 2; e <= 8; e += 2) begin
      chk($sformatf("lap_pop_%0d", e), ld_a, e);
      step();
    end
    lap_ready = 0;
    chk("lap_empty", lv_o[0], 0);

    // push and pop together while full
    clear = 1; step(); clear = 0;
    lap = 1; step(4);
    lap_ready = 1; step();
    lap = 0; lap_ready = 0;
    chk("full_pp_drop", drop_o[0], 0);
    chk("full_pp_valid", lv_o[0], 1);

    // start+stop together; clear+lap together
    clear = 1; step(); clear = 0;
    start = 1; stop = 1; step(); start = 0; stop = 0;
    chk("ss_idle", run_o, 0);
    lap = 1; step(2);
    lap = 1; clear = 1; step(); lap = 0; clear = 0;
    chk("cl_lap_lv", lv_o, 0);
    chk("cl_lap_cnt", cnt_c, 0);

    // async reset mid-run with a full FIFO
    load = 1; load_val = 8'd12; step(); load = 0;
    start = 1; step(); start = 0;
    lap = 1; step(6); lap = 0;
    chk("pre_rst_ovf", ovf_o[0], 1);
    chk("pre_rst_lv", lv_o[0], 1);
    chk("pre_rst_run", run_o[0], 1);
    rst_n = 1'b0;
    #1;
    chk("ar_cnt_a", cnt_a, 0);
    chk("ar_cnt_c", cnt_c, 0);
    chk("ar_run", run_o, 0);
    chk("ar_done", done_o, 0);
    chk("ar_ovf", ovf_o, 0);
    chk("ar_lv", lv_o, 0);
    chk("ar_ld", ld_a, 0);
    chk("ar_drop", drop_o, 0);
    step(2);
    rst_n = 1'b1;
    step(4);
    chk("post_rst_run", run_o, 0);
    chk("post_rst_cnt", cnt_c, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lap_stopwatch.md
LAP_STOPWATCH -- requirements
Module: lap_stopwatch

Interface
REQ-001 SHALL have parameter CNT_W, default 32, count width (4..32).
REQ-002 SHALL have parameter PRESCALE, default 1, clk cycles per count tick (1..65535).
REQ-003 SHALL have parameter LAP_DEPTH, default 4, lap FIFO entries (power of 2, 2..16).
REQ-004 SHALL have parameter WRAP, default 1; 1 = wrap at terminal value, 0 = saturate.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk  in  1  clock; rst_n  in  1  async reset, active low.
REQ-006 SHALL have ports: start in 1 run request; stop in 1 halt request; clear in 1 sync clear; dir in 1 0=up 1=down; load in 1 preload strobe; load_val in CNT_W preload value.
REQ-007 SHALL have ports: lap in 1 capture strobe; lap_ready in 1 consumer pop.
REQ-008 SHALL have outputs: count out CNT_W current value; running out 1 state==RUN; done out 1 state==DONE; ovf out 1 sticky wrap flag; lap_valid out 1 FIFO non-empty; lap_data out CNT_W FIFO head; lap_drop out 1 sticky lap-lost flag.

Function
REQ-009 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-010 SHALL apply per-cycle control priority clear > load > stop > start; start and stop together: stop wins.
REQ-011 IDLE: start -> RUN; stop ignored. RUN: stop -> IDLE. DONE: only clear or load leave it (-> IDLE); start/stop ignored.
REQ-012 clear SHALL set count=0, prescaler=0, ovf=0, lap_drop=0, flush FIFO, state IDLE, in the next cycle.
REQ-013 load SHALL set count=load_val and prescaler=0, state IDLE, ovf unchanged.
REQ-014 Prescaler SHALL advance only in RUN, hold value in IDLE (phase preserved across stop/start), tick when it equals PRESCALE-1 then return to 0.
REQ-015 On tick, count SHALL change by +1 (dir=0) or -1 (dir=1); first tick occurs PRESCALE cycles after the cycle start is sampled.
REQ-016 Up at 2^CNT_W-1 or down at 0 on a tick: WRAP=1 -> wrap modulo 2^CNT_W and set ovf; WRAP=0 -> hold value, enter DONE, ovf unchanged.
REQ-017 lap SHALL push the pre-update count of that cycle into the FIFO in any state.
REQ-018 Push when full and no pop same cycle SHALL drop the entry and set lap_drop; push+pop when full SHALL succeed.
REQ-019 Pop SHALL occur on lap_valid && lap_ready; lap_data SHALL show the oldest entry combinationally from storage, lap_valid reflecting state registered.
REQ-020 lap in the same cycle as clear SHALL be discarded (flush wins).
REQ-021 All outputs SHALL be registered or decoded from registers only; no input-to-output combinational path except none.

Reset
REQ-022 rst_n low SHALL immediately force count=0, prescaler=0, state IDLE, running=0, done=0, ovf=0, lap_drop=0, FIFO empty (lap_valid=0), independent of clk.
REQ-023 Reset mid-RUN SHALL abandon the run; after release the block waits in IDLE for start.

Structure
REQ-024 Package lap_stopwatch_pkg SHALL hold the state enum type and default parameter constants.
REQ-025 FIFO SHALL be a sub-module lap_fifo (params WIDTH, DEPTH; push/pop/full/empty/head, sync flush).

Verification
REQ-026 PRESCALE=4, start 1 cycle, run 40 cycles, stop -> count=10, running=0; start again 2 cycles later -> next tick preserves phase.
REQ-027 CNT_W=4, WRAP=1, up from 15 on tick -> count=0, ovf=1; WRAP=0 -> count holds 15, done=1, start ignored until clear.
REQ-028 dir=1, load_val=3, start, PRESCALE=1 -> 3,2,1,0 then WRAP=0 done=1 / WRAP=1 count=15 (CNT_W=4) ovf=1.
REQ-029 LAP_DEPTH=4, lap_ready=0, 5 laps at counts 2,4,6,8,10 -> lap_valid=1, lap_drop=1, pops return 2,4,6,8.
REQ-030 start+stop same cycle from IDLE -> stays IDLE; clear+lap same cycle -> FIFO empty, count=0.
REQ-031 rst_n asserted asynchronously mid-RUN with full FIFO -> all outputs zero before next clk edge.
